// File: rtl/pointwise_conv_seq.sv
`default_nettype none
// ============================================================================
// Module   : pointwise_conv_seq
// Purpose  : Parametrised 1x1 (pointwise) convolution. One pixel's IN_CH
//            channel vector is accepted per transaction. OUT_CH MACs run in
//            parallel, each stepping through the input channels one per
//            cycle, and the result is rounded, optionally ReLU'd and
//            saturated to OUT_W bits.
// Ports    : clk, rst_n             clock, asynchronous active-low reset
//            in_data/valid/ready    packed input vector (channel c at c*IN_W)
//            out_data/valid/ready   packed results (filter f at f*OUT_W)
//            out_sat                some filter in out_data was clamped
//            wr_en/addr/data        weight (f*IN_CH+c) / bias (OUT_CH*IN_CH+f)
//            wr_err                 1-cycle pulse when a write is dropped
// Revision : 1.0 - initial release
// ============================================================================
module pointwise_conv_seq #(
  parameter int IN_CH   = 3,
  parameter int OUT_CH  = 9,
  parameter int IN_W    = 14,
  parameter int W_W     = 8,
  parameter int OUT_W   = 16,
  parameter int SHIFT   = 0,
  parameter int RELU_EN = 0
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [IN_CH*IN_W-1:0]                 in_data,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic [OUT_CH*OUT_W-1:0]               out_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic                                  out_sat,
  input  logic                                  wr_en,
  input  logic [$clog2(OUT_CH*(IN_CH+1))-1:0]   wr_addr,
  input  logic [W_W-1:0]                        wr_data,
  output logic                                  wr_err
);

  localparam int AW     = $clog2(OUT_CH*(IN_CH+1));
  localparam int N_WGT  = OUT_CH*IN_CH;
  localparam int N_ADDR = OUT_CH*(IN_CH+1);
  localparam int ACC_W  = IN_W + W_W + $clog2(IN_CH+1) + 1;
  // Post-processing width: one bit over the accumulator so the rounding
  // offset cannot overflow, and wide enough to hold the output limits.
  localparam int RW     = (ACC_W + 1 > OUT_W + 1) ? ACC_W + 1 : OUT_W + 1;
  localparam int CH_W   = (IN_CH > 1) ? $clog2(IN_CH) : 1;

  localparam logic signed [RW-1:0] RND_C =
      (SHIFT > 0) ? (RW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
  localparam logic signed [RW-1:0] OUT_MAX = {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [RW-1:0] OUT_MIN = {{(RW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  logic [1:0]               r_state;
  logic [CH_W-1:0]          r_ch;
  logic signed [IN_W-1:0]   r_x   [IN_CH];
  logic signed [W_W-1:0]    r_w   [OUT_CH][IN_CH];
  // Working copy of the weights taken at accept time, so a write landing on
  // the accept edge does not leak into the transaction already started.
  logic signed [W_W-1:0]    r_wk  [OUT_CH][IN_CH];
  logic signed [W_W-1:0]    r_b   [OUT_CH];
  logic signed [ACC_W-1:0]  r_acc [OUT_CH];
  logic [OUT_CH*OUT_W-1:0]  r_out;
  logic                     r_out_valid;
  logic                     r_out_sat;
  logic                     r_wr_err;

  logic                     w_idle;
  logic                     w_addr_ok;
  logic                     w_wr_ok;
  logic signed [IN_W-1:0]   w_x_cur;
  logic signed [ACC_W-1:0]  w_prod [OUT_CH];
  logic [OUT_CH*OUT_W-1:0]  w_res;
  logic                     w_any_sat;

  assign w_idle    = (r_state == S_IDLE);
  assign w_addr_ok = ({1'b0, wr_addr} < (AW+1)'(N_ADDR));
  assign w_wr_ok   = wr_en & w_idle & w_addr_ok;
  assign w_x_cur   = r_x[r_ch];

  always_comb begin
    for (int f = 0; f < OUT_CH; f++) begin
      w_prod[f] = ACC_W'(w_x_cur) * ACC_W'(r_wk[f][r_ch]);
    end
  end

  // Round, optional ReLU, saturate. Every bit of v feeds a comparison, only
  // the low OUT_W bits are forwarded when no clamp is needed.
  always_comb begin
    logic signed [RW-1:0] v;
    w_res     = '0;
    w_any_sat = 1'b0;
    for (int f = 0; f < OUT_CH; f++) begin
      v = (RW'(r_acc[f]) + RND_C) >>> SHIFT;
      if ((RELU_EN != 0) && (v < 0)) begin
        v = '0;
      end
      if (v > OUT_MAX) begin
        w_res[f*OUT_W +: OUT_W] = OUT_MAX[OUT_W-1:0];
        w_any_sat = 1'b1;
      end else if (v < OUT_MIN) begin
        w_res[f*OUT_W +: OUT_W] = OUT_MIN[OUT_W-1:0];
        w_any_sat = 1'b1;
      end else begin
        w_res[f*OUT_W +: OUT_W] = v[OUT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ch        <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_out_sat   <= 1'b0;
      r_wr_err    <= 1'b0;
      for (int c = 0; c < IN_CH; c++) begin
        r_x[c] <= '0;
      end
      for (int f = 0; f < OUT_CH; f++) begin
        r_b[f]   <= '0;
        r_acc[f] <= '0;
        for (int c = 0; c < IN_CH; c++) begin
          r_w[f][c]  <= '0;
          r_wk[f][c] <= '0;
        end
      end
    end else begin
      r_wr_err <= wr_en & ~w_wr_ok;

      if (w_wr_ok) begin
        for (int f = 0; f < OUT_CH; f++) begin
          for (int c = 0; c < IN_CH; c++) begin
            if (wr_addr == AW'(f*IN_CH + c)) begin
              r_w[f][c] <= wr_data;
            end
          end
          if (wr_addr == AW'(N_WGT + f)) begin
            r_b[f] <= wr_data;
          end
        end
      end

      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            for (int c = 0; c < IN_CH; c++) begin
              r_x[c] <= in_data[c*IN_W +: IN_W];
            end
            for (int f = 0; f < OUT_CH; f++) begin
              r_acc[f] <= ACC_W'(r_b[f]);
              for (int c = 0; c < IN_CH; c++) begin
                r_wk[f][c] <= r_w[f][c];
              end
            end
            r_ch    <= '0;
            r_state <= S_ACC;
          end
        end
        S_ACC: begin
          for (int f = 0; f < OUT_CH; f++) begin
            r_acc[f] <= r_acc[f] + w_prod[f];
          end
          r_ch <= r_ch + 1'b1;
          if (r_ch == CH_W'(IN_CH - 1)) begin
            r_state <= S_OUT;
          end
        end
        S_OUT: begin
          // First cycle in OUT registers the result; after that the
          // outputs hold until the downstream handshake.
          if (!r_out_valid) begin
            r_out       <= w_res;
            r_out_sat   <= w_any_sat;
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = w_idle;
  assign out_data  = r_out;
  assign out_valid = r_out_valid;
  assign out_sat   = r_out_sat;
  assign wr_err    = r_wr_err;

endmodule
`default_nettype wire

// File: tb/tb_pointwise_conv_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_pointwise_conv_seq
// Purpose  : Directed self-checking bench for pointwise_conv_seq. Instance
//            dut uses the default parameters, dut2 uses SHIFT=2, RELU_EN=1.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_pointwise_conv_seq;

  logic         clk;
  logic         rst_n;
  logic [41:0]  in_data;
  logic         in_valid;
  logic         in_ready;
  logic [143:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_sat;
  logic         wr_en;
  logic [5:0]   wr_addr;
  logic [7:0]   wr_data;
  logic         wr_err;

  logic [41:0]  in_data2;
  logic         in_valid2;
  logic         in_ready2;
  logic [143:0] out_data2;
  logic         out_valid2;
  logic         out_ready2;
  logic         out_sat2;
  logic         wr_en2;
  logic [5:0]   wr_addr2;
  logic [7:0]   wr_data2;
  logic         wr_err2;

  int n_chk;
  int n_err;

  pointwise_conv_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sat   (out_sat),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_err    (wr_err)
  );

  pointwise_conv_seq #(.SHIFT(2), .RELU_EN(1)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data2),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .out_data  (out_data2),
    .out_valid (out_valid2),
    .out_ready (out_ready2),
    .out_sat   (out_sat2),
    .wr_en     (wr_en2),
    .wr_addr   (wr_addr2),
    .wr_data   (wr_data2),
    .wr_err    (wr_err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [41:0] pack3(input int a, input int b, input int c);
    return {14'(c), 14'(b), 14'(a)};
  endfunction

  function automatic logic signed [31:0] outv(input int f);
    logic signed [15:0] t;
    t = out_data[f*16 +: 16];
    return t;
  endfunction

  function automatic logic signed [31:0] outv2(input int f);
    logic signed [15:0] t;
    t = out_data2[f*16 +: 16];
    return t;
  endfunction

  task automatic wr(input int addr, input int data, input logic exp_err, input string tag);
    wr_en   = 1'b1;
    wr_addr = 6'(addr);
    wr_data = 8'(data);
    tick();
    wr_en = 1'b0;
    chk(tag, wr_err, exp_err);
  endtask

  task automatic wr2(input int addr, input int data);
    wr_en2   = 1'b1;
    wr_addr2 = 6'(addr);
    wr_data2 = 8'(data);
    tick();
    wr_en2 = 1'b0;
  endtask

  task automatic start(input int a, input int b, input int c);
    in_data  = pack3(a, b, c);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int i;
    i = 0;
    while (out_valid !== 1'b1 && i < 20) begin
      tick();
      i++;
    end
    chk(tag, out_valid, 1);
  endtask

  task automatic wait_out2(input string tag);
    int i;
    i = 0;
    while (out_valid2 !== 1'b1 && i < 20) begin
      tick();
      i++;
    end
    chk(tag, out_valid2, 1);
  endtask

  task automatic hs();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hs_valid_low", out_valid, 0);
  endtask

  task automatic hs2();
    out_ready2 = 1'b1;
    tick();
    out_ready2 = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    in_data = '0;   in_valid = 1'b0;   out_ready = 1'b0;
    wr_en = 1'b0;   wr_addr = '0;      wr_data = '0;
    in_data2 = '0;  in_valid2 = 1'b0;  out_ready2 = 1'b0;
    wr_en2 = 1'b0;  wr_addr2 = '0;     wr_data2 = '0;

    // Reset state
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", (out_data === '0), 1);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_wr_err", wr_err, 0);
    rst_n = 1'b1;
    tick();

    // Basic MAC: w[0]={1,2,3}, b[0]=4, x={10,20,30} -> 144
    wr(0, 1, 1'b0, "wr_w00");
    wr(1, 2, 1'b0, "wr_w01");
    wr(2, 3, 1'b0, "wr_w02");
    wr(27, 4, 1'b0, "wr_b0");
    start(10, 20, 30);
    chk("acc_in_ready", in_ready, 0);
    tick(); tick(); tick();
    chk("latency_not_early", out_valid, 0);
    tick();
    chk("latency_4_edges", out_valid, 1);
    chk("basic_out0", outv(0), 144);
    for (int f = 1; f < 9; f++) begin
      chk($sformatf("basic_out%0d", f), outv(f), 0);
    end
    chk("basic_sat", out_sat, 0);

    // Backpressure: a pending vector {1,1,1} must wait for the handshake
    in_data  = pack3(1, 1, 1);
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("bp_hold_data", outv(0), 144);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_hs_valid", out_valid, 0);
    chk("bp_idle_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_accept", in_ready, 0);
    wait_out("bp_wait");
    chk("bp_next_out0", outv(0), 10);
    hs();

    // Write during ACC is dropped
    start(10, 20, 30);
    wr(0, 100, 1'b1, "acc_wr_err");
    tick();
    chk("acc_wr_err_pulse", wr_err, 0);
    wait_out("acc_wr_wait");
    chk("acc_wr_old_w", outv(0), 144);
    hs();

    // Out-of-range address
    wr(36, 55, 1'b1, "oor_wr_err");
    tick();
    chk("oor_wr_err_pulse", wr_err, 0);
    start(10, 20, 30);
    wait_out("oor_wait");
    chk("oor_no_change", outv(0), 144);
    hs();

    // Write in the same cycle as accept: this vector uses the old weight
    wr_en    = 1'b1;  wr_addr = 6'd0;  wr_data = 8'd5;
    in_data  = pack3(10, 20, 30);
    in_valid = 1'b1;
    tick();
    wr_en    = 1'b0;
    in_valid = 1'b0;
    chk("same_wr_err", wr_err, 0);
    chk("same_accept", in_ready, 0);
    wait_out("same_wait");
    chk("same_old_w", outv(0), 144);
    hs();
    start(10, 20, 30);
    wait_out("same_new_wait");
    chk("same_new_w", outv(0), 184);
    hs();

    // Saturation
    wr(0, 127, 1'b0, "sat_w00");
    wr(1, 127, 1'b0, "sat_w01");
    wr(2, 127, 1'b0, "sat_w02");
    wr(27, 127, 1'b0, "sat_b0");
    start(8191, 8191, 8191);
    wait_out("satp_wait");
    chk("satp_out0", outv(0), 32767);
    chk("satp_out1", outv(1), 0);
    chk("satp_flag", out_sat, 1);
    hs();
    start(-8192, -8192, -8192);
    wait_out("satn_wait");
    chk("satn_out0", outv(0), -32768);
    chk("satn_flag", out_sat, 1);
    hs();

    // Asynchronous reset mid-ACC, weights return to 0
    start(10, 20, 30);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", in_ready, 1);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", (out_data === '0), 1);
    chk("arst_out_sat", out_sat, 0);
    #2;
    rst_n = 1'b1;
    tick();
    start(10, 20, 30);
    wait_out("arst_wait");
    chk("arst_w_cleared", outv(0), 0);
    hs();

    // SHIFT=2, RELU_EN=1: acc=146 -> 37, acc=-5 -> 0
    wr2(0, 1);
    wr2(1, 2);
    wr2(2, 3);
    wr2(27, 6);
    in_data2  = pack3(10, 20, 30);
    in_valid2 = 1'b1;
    tick();
    in_valid2 = 1'b0;
    wait_out2("rnd_wait");
    chk("rnd_out0", outv2(0), 37);
    chk("rnd_sat", out_sat2, 0);
    hs2();
    in_data2  = pack3(-11, 0, 0);
    in_valid2 = 1'b1;
    tick();
    in_valid2 = 1'b0;
    wait_out2("relu_wait");
    chk("relu_out0", outv2(0), 0);
    chk("relu_sat", out_sat2, 0);
    hs2();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
